poly_sub_controller: RTL and testbench

Sequencer that computes the coefficient-wise modular difference of two length-N polynomials held in external synchronous-read memories. It drives the read address, streams each operand pair through one embedded `modular_subtractor` (2-cycle latency, fixed modulus Q), and writes each result to a destination memory port. It sits beside the NTT core, handling polynomial subtraction between transform stages without CPU involvement.

---
 rtl/poly_sub_controller.sv | 132 +++++++++++++
 tb/tb_poly_sub_controller.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/poly_sub_controller.sv
// poly_sub_controller
//
// Streams two length-N polynomials (N = 2**LOGN) out of synchronous-read
// source memories and writes their coefficient-wise difference mod Q to a
// destination memory. Each index i is read in cycle c0+i and written in
// cycle c0+i+3, so in-place operation on either source is safe.
//
// Parameters
//   Q     modulus, 0 < Q < 2**30
//   LOGN  log2 of the polynomial length
//
// Ports
//   clk, rst         clock; synchronous active-high reset
//   start, swap      run request (accepted in idle only); operand order
//                    latched with start (0: A-B, 1: B-A)
//   busy, done       run in progress; one-cycle pulse after the last write
//   rd_en, rd_addr   shared read port for both source memories
//   a_data, b_data   operands, valid the cycle after rd_en
//   wr_en, wr_addr,
//   wr_data          result write port
module poly_sub_controller #(
  parameter logic [29:0] Q    = 30'd0,
  parameter int unsigned LOGN = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            swap,
  output logic            busy,
  output logic            done,
  output logic            rd_en,
  output logic [LOGN-1:0] rd_addr,
  input  logic [29:0]     a_data,
  input  logic [29:0]     b_data,
  output logic            wr_en,
  output logic [LOGN-1:0] wr_addr,
  output logic [29:0]     wr_data
);

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

  state_e          state_q, state_d;
  logic [LOGN-1:0] cnt_q, cnt_d;
  logic [1:0]      drain_q, drain_d;
  logic            swap_q, swap_d;

  // Valid bit and index travel alongside the datapath: stage k holds the
  // read issued k cycles ago.
  logic [2:0]            vld_q;
  logic [2:0][LOGN-1:0]  idx_q;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    swap_d  = swap_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRead;
          cnt_d   = '0;
          swap_d  = swap;
        end
      end
      StRead: begin
        // Counter wraps back to 0 after the last index, leaving rd_addr at 0.
        cnt_d = cnt_q + LOGN'(1);
        if (&cnt_q) begin
          state_d = StDrain;
          drain_d = 2'd0;
        end
      end
      StDrain: begin
        drain_d = drain_q + 2'd1;
        if (drain_q == 2'd2) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      drain_q <= 2'd0;
      swap_q  <= 1'b0;
      vld_q   <= 3'b000;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
      swap_q  <= swap_d;
      vld_q   <= {vld_q[1:0], rd_en};
      idx_q   <= {idx_q[1:0], rd_addr};
    end
  end

  assign busy    = (state_q == StRead) || (state_q == StDrain);
  assign done    = (state_q == StDone);
  assign rd_en   = (state_q == StRead);
  assign rd_addr = cnt_q;

  // Embedded modular subtractor, two-cycle latency, free-running. Its first
  // register is the operand-mux register capturing data in the cycle it
  // arrives; the second applies the single +Q correction.
  logic [29:0] op_a, op_b;
  logic [30:0] diff_q;
  logic [29:0] res_q;

  assign op_a = swap_q ? b_data : a_data;
  assign op_b = swap_q ? a_data : b_data;

  always_ff @(posedge clk) begin
    diff_q <= {1'b0, op_a} - {1'b0, op_b};
    // Sign bit set means a < b; adding Q modulo 2**30 lands in [0, Q).
    res_q  <= diff_q[30] ? (diff_q[29:0] + Q) : diff_q[29:0];
  end

  assign wr_en   = vld_q[2];
  assign wr_addr = idx_q[2];
  assign wr_data = res_q;

endmodule

// File: tb/tb_poly_sub_controller.sv
module tb_poly_sub_controller;

  localparam int unsigned LOGN = 3;
  localparam int          N    = 8;
  localparam logic [29:0] Q    = 30'd12289;

  logic            clk;
  logic            rst;
  logic            start;
  logic            swap;
  logic            busy;
  logic            done;
  logic            rd_en;
  logic [LOGN-1:0] rd_addr;
  logic [29:0]     a_data;
  logic [29:0]     b_data;
  logic            wr_en;
  logic [LOGN-1:0] wr_addr;
  logic [29:0]     wr_data;

  logic [29:0] mem_a [N];
  logic [29:0] mem_b [N];
  int unsigned expv  [N];

  int passed = 0;
  int total  = 0;

  poly_sub_controller #(
    .Q    (Q),
    .LOGN (LOGN)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .swap    (swap),
    .busy    (busy),
    .done    (done),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .a_data  (a_data),
    .b_data  (b_data),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read source memories.
  always @(posedge clk) begin
    if (rd_en) begin
      a_data <= mem_a[rd_addr];
      b_data <= mem_b[rd_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Reference: true mathematical difference reduced into [0, Q).
  function automatic int unsigned ref_sub(input int unsigned x, input int unsigned y);
    return (x + 32'(Q) - y) % 32'(Q);
  endfunction

  task automatic fill_random();
    for (int i = 0; i < N; i++) begin
      mem_a[i] = 30'($urandom_range(0, 12288));
      mem_b[i] = 30'($urandom_range(0, 12288));
    end
  endtask

  // Called at a negedge in an idle cycle. Checks every cycle c0..c0+N+3 and
  // the following idle cycle. abort_at >= 0 raises rst in cycle c0+abort_at.
  task automatic run(input bit sw, input bit hold, input bit toggle, input bit late,
                     input int abort_at);
    bit wr_exp;
    for (int i = 0; i < N; i++) begin
      expv[i] = sw ? ref_sub(32'(mem_b[i]), 32'(mem_a[i]))
                   : ref_sub(32'(mem_a[i]), 32'(mem_b[i]));
    end
    start = 1'b1;
    swap  = sw;
    @(negedge clk);
    if (!hold) start = 1'b0;
    for (int k = 0; k <= N + 3; k++) begin
      wr_exp = (k >= 3) && (k <= N + 2);
      chk("busy", 32'(busy), 32'(k <= N + 2));
      chk("done", 32'(done), 32'(k == N + 3));
      chk("rd_en", 32'(rd_en), 32'(k < N));
      if (k < N) chk("rd_addr", 32'(rd_addr), 32'(k));
      chk("wr_en", 32'(wr_en), 32'(wr_exp));
      if (wr_exp) begin
        chk("wr_addr", 32'(wr_addr), 32'(k - 3));
        chk("wr_data", 32'(wr_data), expv[k-3]);
      end
      if (k == abort_at) begin
        rst = 1'b1;
        return;
      end
      if (toggle && k == 2) swap = ~sw;
      if (late) start = (k >= N) && (k <= N + 3);
      @(negedge clk);
    end
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_rd_en", 32'(rd_en), 32'd0);
    chk("idle_wr_en", 32'(wr_en), 32'd0);
    start = 1'b0;
    swap  = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    swap  = 1'b0;
    for (int i = 0; i < N; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic run: every difference is 10.
    for (int i = 0; i < N; i++) begin
      mem_a[i] = 30'(i + 10);
      mem_b[i] = 30'(i);
    end
    run(1'b0, 1'b0, 1'b0, 1'b0, -1);

    // Wrap-around, started in the first idle cycle after done.
    for (int i = 0; i < N; i++) begin
      mem_a[i] = 30'd0;
      mem_b[i] = 30'd1;
    end
    run(1'b0, 1'b0, 1'b0, 1'b0, -1);

    // Boundary pairs.
    fill_random();
    mem_a[0] = 30'd12288; mem_b[0] = 30'd0;
    mem_a[1] = 30'd0;     mem_b[1] = 30'd12288;
    mem_a[2] = 30'd5000;  mem_b[2] = 30'd5000;
    mem_a[3] = 30'd12288; mem_b[3] = 30'd12288;
    run(1'b0, 1'b0, 1'b0, 1'b0, -1);

    // Swap, with the input toggled mid-run.
    for (int i = 0; i < N; i++) begin
      mem_a[i] = 30'd3;
      mem_b[i] = 30'd5;
    end
    run(1'b1, 1'b0, 1'b1, 1'b0, -1);

    // start held high through a whole run.
    fill_random();
    run(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0, -1);

    // start pulsed during drain and done.
    fill_random();
    run(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b1, -1);

    // Reset in cycle c0+4.
    fill_random();
    run(1'b0, 1'b0, 1'b0, 1'b0, 4);
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_rd_en", 32'(rd_en), 32'd0);
    chk("abort_rd_addr", 32'(rd_addr), 32'd0);
    chk("abort_wr_en", 32'(wr_en), 32'd0);
    chk("abort_wr_addr", 32'(wr_addr), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("abort_quiet_wr_en", 32'(wr_en), 32'd0);
      chk("abort_quiet_busy", 32'(busy), 32'd0);
    end

    // Full runs after the abort, random data and order.
    for (int r = 0; r < 4; r++) begin
      fill_random();
      run(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, -1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
